// File: rtl/cache_pkg.sv
// Shared cache geometry constants, memory-controller state encoding and
// the word-address builder used by the line memory controller.
package cache_pkg;

  localparam int BLOCK_SIZE  = 64;
  localparam int WORD_SIZE   = 4;
  localparam int NO_WORDS    = BLOCK_SIZE / WORD_SIZE;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int LINE_BITS   = 32 - OFFSET_BITS;
  localparam int WORD_BITS   = $clog2(WORD_SIZE);
  localparam int CNT_BITS    = $clog2(NO_WORDS);

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NO_WORDS - 1);

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WB   = 2'd1;
  localparam state_t S_FILL = 2'd2;
  localparam state_t S_DONE = 2'd3;

  // Byte address of word idx within a line: {line, idx, byte offset 0}.
  function automatic logic [31:0] build_mem_addr(input logic [LINE_BITS-1:0] line,
                                                 input logic [CNT_BITS-1:0]  idx);
    return {line, idx, {WORD_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_line_mem_ctrl.sv
// Line transaction engine below the cache: optional dirty-victim write-back
// followed by a 16-word refill over a word-wide req/ack memory bus.
module cache_line_mem_ctrl
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_wb,
  input  logic [LINE_BITS-1:0] req_wb_line,
  input  logic [LINE_BITS-1:0] req_fill_line,
  output logic                 ready,
  output logic [CNT_BITS-1:0]  wb_idx,
  input  logic [31:0]          wb_word,
  output logic                 fill_we,
  output logic [CNT_BITS-1:0]  fill_idx,
  output logic [31:0]          fill_data,
  output logic                 done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata
);

  state_t               state;
  logic [CNT_BITS-1:0]  cnt;
  logic                 req_q;
  logic [LINE_BITS-1:0] wb_line_q;
  logic [LINE_BITS-1:0] fill_line_q;
  logic                 last_word;

  logic                 fill_we_p1;
  logic [CNT_BITS-1:0]  fill_idx_p1;
  logic [31:0]          fill_data_p1;

  assign last_word = (cnt == LAST_IDX);

  // req_q rises one cycle after a phase is entered from IDLE and then stays
  // high across both phases, so the WB->FILL handover has no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      req_q        <= 1'b0;
      wb_line_q    <= '0;
      fill_line_q  <= '0;
      fill_we_p1   <= 1'b0;
      fill_idx_p1  <= '0;
      fill_data_p1 <= '0;
    end else begin
      fill_we_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wb_line_q   <= req_wb_line;
            fill_line_q <= req_fill_line;
            cnt         <= '0;
            state       <= req_wb ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last_word) state <= S_FILL;
          end
        end
        S_FILL: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (mem_ack) begin
            // Stage p1: refill word captured for the cache data array
            fill_we_p1   <= 1'b1;
            fill_idx_p1  <= cnt;
            fill_data_p1 <= mem_rdata;
            cnt          <= cnt + 1'b1;
            if (last_word) begin
              state <= S_DONE;
              req_q <= 1'b0;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign wb_idx    = cnt;
  assign mem_req   = req_q;
  assign mem_we    = req_q && (state == S_WB);
  assign mem_wdata = mem_we ? wb_word : 32'd0;
  assign mem_addr  = !req_q            ? 32'd0 :
                     (state == S_WB)   ? build_mem_addr(wb_line_q, cnt) :
                                         build_mem_addr(fill_line_q, cnt);

  assign fill_we   = fill_we_p1;
  assign fill_idx  = fill_idx_p1;
  assign fill_data = fill_data_p1;

endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Scoreboard bench for cache_line_mem_ctrl: directed line transactions against
// a parameterised-latency memory model, with queue-based bus/refill/done checks.
module tb_cache_line_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_wb;
  logic [25:0] req_wb_line;
  logic [25:0] req_fill_line;
  logic        ready;
  logic [3:0]  wb_idx;
  logic [31:0] wb_word;
  logic        fill_we;
  logic [3:0]  fill_idx;
  logic [31:0] fill_data;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } fill_t;

  bus_t  bus_q[$];
  fill_t fill_q[$];
  int    done_q[$];

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int lat   = 1;
  int wcnt  = 0;
  logic stray_ack = 1'b0;

  cache_line_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wb(req_wb),
    .req_wb_line(req_wb_line), .req_fill_line(req_fill_line),
    .ready(ready), .wb_idx(wb_idx), .wb_word(wb_word),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  // Memory model: acks after lat cycles of request, read data equals address.
  assign mem_ack   = stray_ack | (mem_req && (wcnt == lat - 1));
  assign mem_rdata = mem_addr;
  assign wb_word   = 32'hDEAD0000 + {28'd0, wb_idx};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expected entries whenever the DUT presents a bus word,
  // a refill strobe or a done pulse.
  initial begin
    bus_t        eb;
    fill_t       ef;
    int          ed;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic        prev_we    = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_req",  32'(mem_req), 32'd1);
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_we",   32'(mem_we), 32'(prev_we));
      end
      prev_stall = mem_req && !mem_ack;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      if (mem_req && mem_ack) begin
        if (bus_q.size() == 0) fail_now("bus_unexpected");
        else begin
          eb = bus_q.pop_front();
          chk("mem_we",    32'(mem_we), 32'(eb.we));
          chk("mem_addr",  mem_addr, eb.addr);
          chk("mem_wdata", mem_wdata, eb.wdata);
        end
      end
      if (fill_we) begin
        if (fill_q.size() == 0) fail_now("fill_unexpected");
        else begin
          ef = fill_q.pop_front();
          chk("fill_idx",  32'(fill_idx), 32'(ef.idx));
          chk("fill_data", fill_data, ef.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail_now("done_unexpected");
        else begin
          ed = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(ed));
          chk("done_last_fill", {27'd0, fill_we, fill_idx}, {27'd0, 1'b1, 4'hF});
        end
      end
    end
  end

  task automatic push_words(input logic wb, input logic [25:0] wl, input logic [25:0] fl,
                            input int nbus, input int nfill);
    if (wb)
      for (int k = 0; k < 16; k++)
        bus_q.push_back('{we: 1'b1, addr: (32'(wl) << 6) + 32'(4 * k),
                          wdata: 32'hDEAD0000 + 32'(k)});
    for (int k = 0; k < nbus; k++)
      bus_q.push_back('{we: 1'b0, addr: (32'(fl) << 6) + 32'(4 * k), wdata: 32'd0});
    for (int k = 0; k < nfill; k++)
      fill_q.push_back('{idx: 4'(k), data: (32'(fl) << 6) + 32'(4 * k)});
  endtask

  task automatic start(input logic wb, input logic [25:0] wl, input logic [25:0] fl,
                       input bit keep);
    @(negedge clk);
    chk("ready_idle", 32'(ready), 32'd1);
    req_wb        = wb;
    req_wb_line   = wl;
    req_fill_line = fl;
    req_valid     = 1'b1;
    done_q.push_back(cyc + 2 + (wb ? 32 : 16) * lat);
    push_words(wb, wl, fl, 16, 16);
    @(posedge clk);
    #1;
    chk("ready_busy", 32'(ready), 32'd0);
    if (!keep) req_valid = 1'b0;
    req_wb        = 1'b0;
    req_wb_line   = 26'h3FFFFFF;
    req_fill_line = 26'h3FFFFFF;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},     32'(ready),     32'd1);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_fill_we"},   32'(fill_we),   32'd0);
    chk({tag, "_fill_idx"},  32'(fill_idx),  32'd0);
    chk({tag, "_fill_data"}, fill_data,      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_wb_idx"},    32'(wb_idx),    32'd0);
  endtask

  initial begin
    int e1;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_wb        = 1'b0;
    req_wb_line   = '0;
    req_fill_line = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Stray acks while idle must not move the FSM or counter.
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ready",   32'(ready),   32'd1);
    chk("stray_mem_req", 32'(mem_req), 32'd0);
    chk("stray_wb_idx",  32'(wb_idx),  32'd0);
    stray_ack = 1'b0;

    // Fill-only, zero-wait memory.
    lat = 1;
    start(1'b0, 26'h0, 26'h0000001, 1'b0);
    wait_done(100);

    // Write-back then refill.
    start(1'b1, 26'h0000002, 26'h0000003, 1'b0);
    wait_done(100);

    // Slow memory, three cycles per word.
    lat = 3;
    start(1'b0, 26'h0, 26'h0000004, 1'b0);
    wait_done(200);
    lat = 1;

    // req_valid held high: new address ignored until IDLE, then taken back-to-back.
    start(1'b0, 26'h0, 26'h0000006, 1'b1);
    e1 = cyc;
    req_fill_line = 26'h0000005;
    done_q.push_back(e1 + 36);
    push_words(1'b0, 26'h0, 26'h0000005, 16, 16);
    repeat (4) @(negedge clk);
    chk("hold_req_ready", 32'(ready), 32'd0);
    wait_done(100);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_accepted", 32'(ready), 32'd0);
    req_valid     = 1'b0;
    req_fill_line = '0;
    wait_done(100);

    // Reset during word 7 of refill aborts without done or further fill_we.
    @(negedge clk);
    req_fill_line = 26'h0000008;
    req_valid     = 1'b1;
    push_words(1'b0, 26'h0, 26'h0000008, 8, 7);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);

    start(1'b0, 26'h0, 26'h0000007, 1'b0);
    wait_done(100);

    repeat (3) @(negedge clk);
    chk("bus_q_left",  32'(bus_q.size()),  32'd0);
    chk("fill_q_left", 32'(fill_q.size()), 32'd0);
    chk("done_q_left", 32'(done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
